// File: rtl/dilithium_pkg.sv
// rtl/dilithium_pkg.sv - shared constants and state type for the polynomial I/O path
package dilithium_pkg;

    localparam int COEFF_W = 24;
    localparam int LANES   = 4;
    localparam int WORDS   = 64;

    localparam logic [23:0] Q = 24'd8380417;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_UNLOAD,
        ST_FINISH
    } poly_io_state_t;

endpackage

// File: rtl/coeff_lane_mux.sv
// rtl/coeff_lane_mux.sv - lane select (unpack) and lane replace (pack) on one BRAM word
module coeff_lane_mux #(
    parameter int COEFF_W = 24,
    parameter int LANES   = 4
) (
    input  logic [COEFF_W*LANES-1:0]   word_i,
    input  logic [$clog2(LANES)-1:0]   sel_i,
    input  logic [COEFF_W-1:0]         ins_i,
    output logic [COEFF_W-1:0]         lane_o,
    output logic [COEFF_W*LANES-1:0]   word_o
);

    always_comb begin
        lane_o = word_i[int'(sel_i)*COEFF_W +: COEFF_W];
        word_o = word_i;
        word_o[int'(sel_i)*COEFF_W +: COEFF_W] = ins_i;
    end

endmodule

// File: rtl/poly_io_unit.sv
// rtl/poly_io_unit.sv - polynomial stream<->BRAM mover; POLY_IO_REDUCE_EN adds input reduction mod Q
module poly_io_unit #(
    parameter int COEFF_W = dilithium_pkg::COEFF_W,
    parameter int LANES   = dilithium_pkg::LANES,
    parameter int WORDS   = dilithium_pkg::WORDS
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       dir,
    output logic                       busy,
    output logic                       done,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [COEFF_W-1:0]         s_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [COEFF_W-1:0]         m_data,
    output logic                       m_last,
    output logic [$clog2(WORDS)-1:0]   addra,
    input  logic [COEFF_W*LANES-1:0]   doa,
    output logic [$clog2(WORDS)-1:0]   addrb,
    output logic                       web,
    output logic [COEFF_W*LANES-1:0]   dib
);
    import dilithium_pkg::*;

    localparam int AW = $clog2(WORDS);
    localparam int LW = $clog2(LANES);
    localparam int DW = COEFF_W * LANES;
    localparam logic [AW-1:0] LAST_WORD = AW'(WORDS - 1);
    localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

    poly_io_state_t state_q, state_d;
    logic [AW-1:0]  word_q, word_d;
    logic [AW-1:0]  raddr_q, raddr_d;
    logic [LW-1:0]  lane_q, lane_d;
    logic [DW-1:0]  data_q, data_d;
    logic           wr_q, wr_d;
    logic           prime_q, prime_d;
    logic           full_q, full_d;

    logic [COEFF_W-1:0] s_coeff;
    logic [COEFF_W-1:0] lane_sel;
    logic [DW-1:0]      data_ins;

    always_comb begin
        s_coeff = s_data;
`ifdef POLY_IO_REDUCE_EN
        if (s_data >= Q) begin
            s_coeff = s_data - Q;
        end
`endif
    end

    // data_q is the lane assembly register in LOAD and the unpack word register in UNLOAD
    coeff_lane_mux #(
        .COEFF_W (COEFF_W),
        .LANES   (LANES)
    ) u_lane_mux (
        .word_i (data_q),
        .sel_i  (lane_q),
        .ins_i  (s_coeff),
        .lane_o (lane_sel),
        .word_o (data_ins)
    );

    assign busy    = (state_q == ST_LOAD) || (state_q == ST_UNLOAD);
    assign done    = (state_q == ST_FINISH);
    assign s_ready = (state_q == ST_LOAD) && !(wr_q && (word_q == LAST_WORD));
    assign m_valid = (state_q == ST_UNLOAD) && full_q;
    assign m_data  = m_valid ? lane_sel : '0;
    assign m_last  = m_valid && (word_q == LAST_WORD) && (lane_q == LAST_LANE);
    assign addra   = (state_q == ST_UNLOAD) ? raddr_q : '0;
    assign web     = wr_q;
    assign addrb   = wr_q ? word_q : '0;
    assign dib     = wr_q ? data_q : '0;

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        raddr_d = raddr_q;
        lane_d  = lane_q;
        data_d  = data_q;
        wr_d    = 1'b0;
        prime_d = prime_q;
        full_d  = full_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = dir ? ST_UNLOAD : ST_LOAD;
                    word_d  = '0;
                    raddr_d = '0;
                    lane_d  = '0;
                    prime_d = 1'b0;
                    full_d  = 1'b0;
                end
            end
            ST_LOAD: begin
                if (wr_q) begin
                    word_d = word_q + 1'b1;
                    if (word_q == LAST_WORD) begin
                        state_d = ST_FINISH;
                    end
                end
                if (s_valid && s_ready) begin
                    data_d = data_ins;
                    lane_d = lane_q + 1'b1;
                    if (lane_q == LAST_LANE) begin
                        wr_d = 1'b1;
                    end
                end
            end
            ST_UNLOAD: begin
                // Two priming cycles: issue address 0, then capture word 0 while address 1 is read
                if (!full_q) begin
                    if (!prime_q) begin
                        prime_d = 1'b1;
                        raddr_d = raddr_q + 1'b1;
                    end else begin
                        data_d = doa;
                        full_d = 1'b1;
                    end
                end else if (m_ready) begin
                    lane_d = lane_q + 1'b1;
                    if (lane_q == LAST_LANE) begin
                        if (word_q == LAST_WORD) begin
                            state_d = ST_FINISH;
                        end else begin
                            data_d  = doa;
                            word_d  = word_q + 1'b1;
                            raddr_d = raddr_q + 1'b1;
                        end
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            word_q  <= '0;
            raddr_q <= '0;
            lane_q  <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
            prime_q <= 1'b0;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            raddr_q <= raddr_d;
            lane_q  <= lane_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            prime_q <= prime_d;
            full_q  <= full_d;
        end
    end

endmodule

// File: doc/poly_io_unit.md
# poly_io_unit

Moves one 256-coefficient polynomial between a 24-bit coefficient stream and the 64×96-bit polynomial BRAM used by the NTT/arithmetic operation unit. Load direction accepts coefficients on a valid/ready stream, packs four per word and writes BRAM port B. Unload direction reads BRAM port A, unpacks and emits coefficients on a valid/ready stream. It sits between the host/Keccak-side datapath and the operation unit's BRAM; it owns the BRAM ports only while `busy`.

## Interface
Parameters:
- `COEFF_W`, 24, coefficient width.
- `LANES`, 4, coefficients per BRAM word.
- `WORDS`, 64, words per polynomial.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `dir`  in  1  0 = load (stream→BRAM), 1 = unload (BRAM→stream); sampled with `start`.
- `busy`  out  1  high from the cycle after accepted `start` until `done`.
- `done`  out  1  one-cycle completion pulse.
- `s_valid`  in  1,  `s_ready`  out  1,  `s_data`  in  24: load stream.
- `m_valid`  out  1,  `m_ready`  in  1,  `m_data`  out  24,  `m_last`  out  1: unload stream.
- `addra`  out  6,  `doa`  in  96: BRAM read port, registered read with 1-cycle latency.
- `addrb`  out  6,  `web`  out  1,  `dib`  out  96: BRAM write port.

## Operation
- States: IDLE, LOAD, UNLOAD, FINISH.
- IDLE: `start` with `dir`=0 → LOAD; with `dir`=1 → UNLOAD. Word index and lane counter cleared. `start` outside IDLE is ignored.
- Packing: lane k occupies `[24k+23:24k]`; stream order is word 0 lane 0, lane 1, … word 63 lane 3.
- LOAD: `s_ready`=1. Each handshake writes `s_data` into lane register `lane` and increments `lane`.
  - On the lane-3 handshake, the next cycle drives `web`=1, `addrb`=word index and `dib`={lane3,lane2,lane1,lane0}, then the word index increments.
  - After word 63 is written, `s_ready` drops and the state goes to FINISH.
- UNLOAD: `addra` is the word to prefetch. Entering UNLOAD drives `addra`=0. The following cycle captures `doa` into the word register and sets `addra`=1.
  - `m_valid`=1 and `m_data`=current lane of the word register.
  - On the lane-3 handshake, `doa` (already holding word index+1) is captured and `addra` advances.
  - `m_last`=1 on word 63 lane 3. Its handshake → FINISH.
- FINISH: `done`=1 for one cycle, `busy`=0, → IDLE.
- Backpressure: `m_data` and `m_valid` are held stable while `m_ready`=0. `addra` is stable whenever the word register may load, so no skid buffer is needed.
- Reset (any time): state IDLE; all outputs 0, including `s_ready`, `m_valid`, `web`, `done`, `busy` and addresses. A partially loaded polynomial is abandoned and no further writes are issued.

## Timing
- Load: the last write (`web`) occurs 1 cycle after the 256th handshake. `done` follows 1 cycle later.
- Unload: `m_valid` first rises 2 cycles after the `start` edge. Sustained throughput is 1 coefficient/cycle with `m_ready` held high. `done` comes 1 cycle after the `m_last` handshake.
- Minimum load duration is 258 cycles from the first handshake to `done`.
- `web` is never asserted in UNLOAD. `addra` is don't-care in LOAD and driven 0.

## Configuration
- `POLY_IO_REDUCE_EN` defined: in LOAD, each `s_data` ≥ Q (8380417) is replaced by `s_data`−Q before packing (single conditional subtract, combinational, no added latency).
- Undefined: `s_data` is packed unmodified.

## Structure
- Shared package (`dilithium_pkg`): `Q`=24'd8380417, `COEFF_W`, `LANES`, `WORDS`, and the state enum `poly_io_state_t`.
- One sub-module is natural: `coeff_lane_mux`, a 4:1 lane select/pack helper used for both unpack (`m_data`) and pack (`dib`).

## Test plan
- Load ramp: send coefficients 0..255 with `s_valid` held high → `web` pulses 64 times, word 5 `dib`=0x000017_000016_000015_000014, `done` 1 cycle after the last write.
- Unload with a random stall pattern on `m_ready` over a BRAM model filled with the ramp → output 0..255 in order, no duplicates or drops, `m_last` only on 255.
- Unload with `m_ready`=1 → first `m_valid` 2 cycles after `start`, 256 consecutive beats, `done` at beat 256+1.
- `rst_n` low at coefficient 100 of a load → `web`, `s_ready` and `busy` go to 0 immediately. A new `start` after release behaves as fresh.
- `start` pulsed while `busy` → ignored: no restart, single `done`.
- With `POLY_IO_REDUCE_EN`: input 8380417 → lane value 0. Input 8380416 → unchanged. Input 0xFFFFFF → 0x801FFE.
